// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the MDU countdown; it is loaded with latency-1 and counts to zero.
  function automatic int mdu_cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count increments, holding at the maximum value once reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/bubble sequencer for load-use, redirect and MDU hazards
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1_addrD,
  input  logic [4:0]       i_rs2_addrD,
  input  logic             i_rs1_useD,
  input  logic             i_rs2_useD,
  input  logic [4:0]       i_rd_addrE,
  input  logic             i_rd_wrenE,
  input  logic             i_mem_rdenE,
  input  logic             i_redirectE,
  input  logic             i_mdu_reqE,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_stallE,
  output logic             o_flushD,
  output logic             o_flushE,
  output logic             o_bubbleM,
  output logic             o_mdu_start,
  output logic             o_mdu_validE,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int CW = mdu_cnt_w(MDU_LATENCY);

  hz_state_e        state;
  hz_state_e        state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             luse;
  logic [CNT_W-1:0] perf_cnt;

  // Load in EX whose destination is read by the ID instruction; x0 never creates a hazard.
  assign luse = i_mem_rdenE & i_rd_wrenE & (i_rd_addrE != REG_X0) &
                ((i_rs1_useD & (i_rs1_addrD == i_rd_addrE)) |
                 (i_rs2_useD & (i_rs2_addrD == i_rd_addrE)));

  // Pipeline controls and next FSM state; MDU dominates, then redirect, then load-use.
  always_comb begin
    o_stallF     = 1'b0;
    o_stallD     = 1'b0;
    o_stallE     = 1'b0;
    o_flushD     = 1'b0;
    o_flushE     = 1'b0;
    o_bubbleM    = 1'b0;
    o_mdu_start  = 1'b0;
    o_mdu_validE = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    if (!i_rst_n) begin
      o_flushD  = 1'b1;
      o_flushE  = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (state == MDU_BUSY) begin
      if (cnt != '0) begin
        o_stallF  = 1'b1;
        o_stallD  = 1'b1;
        o_stallE  = 1'b1;
        o_bubbleM = 1'b1;
        cnt_nxt   = cnt - CW'(1);
      end else begin
        // Release cycle: the still-asserted request belongs to this same op, so no relaunch.
        o_mdu_validE = 1'b1;
        state_nxt    = RUN;
      end
    end else if (i_mdu_reqE) begin
      o_mdu_start = 1'b1;
      o_stallF    = 1'b1;
      o_stallD    = 1'b1;
      o_stallE    = 1'b1;
      o_bubbleM   = 1'b1;
      cnt_nxt     = CW'(MDU_LATENCY - 1);
      state_nxt   = MDU_BUSY;
    end else if (i_redirectE) begin
      o_flushD = 1'b1;
      o_flushE = 1'b1;
    end else if (luse) begin
      o_stallF = 1'b1;
      o_stallD = 1'b1;
      o_flushE = 1'b1;
    end
  end

  // FSM state and MDU countdown registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Only one class of EX instruction can be present at a time.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert ($onehot0({i_mdu_reqE, i_mem_rdenE, i_redirectE}))
        else $error("hazard_controller: conflicting EX instruction classes");
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (o_stallF),
    .cnt   (perf_cnt)
  );

  assign o_busy         = i_rst_n & (state == MDU_BUSY);
  assign o_stall_cycles = i_rst_n ? perf_cnt : '0;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0, rde = '0;
  logic          u1 = 0, u2 = 0, wren = 0, rden = 0, redir = 0, mdu = 0;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m;
  logic          mdu_start, mdu_valid, busy;
  logic [CW-1:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;
  int age = -1;
  int perf = 0;

  hazard_controller #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_addrD(rs1), .i_rs2_addrD(rs2), .i_rs1_useD(u1), .i_rs2_useD(u2),
    .i_rd_addrE(rde), .i_rd_wrenE(wren), .i_mem_rdenE(rden),
    .i_redirectE(redir), .i_mdu_reqE(mdu),
    .o_stallF(stall_f), .o_stallD(stall_d), .o_stallE(stall_e),
    .o_flushD(flush_d), .o_flushE(flush_e), .o_bubbleM(bubble_m),
    .o_mdu_start(mdu_start), .o_mdu_validE(mdu_valid), .o_busy(busy),
    .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: an MDU op occupies EX for LAT stall cycles then one valid cycle,
  // tracked by its age since launch; everything else follows the priority rules.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [8:0] a;
    logic luse_m;
    logic e_sf, e_sd, e_se, e_fd, e_fe, e_bm, e_st, e_va, e_bz;
    luse_m = rden && wren && (rde != 0) &&
             ((u1 && rs1 == rde) || (u2 && rs2 == rde));
    {e_sf, e_sd, e_se, e_fd, e_fe, e_bm, e_st, e_va, e_bz} = '0;
    if (!rst_n) begin
      e_fd = 1; e_fe = 1;
    end else if (age >= 0) begin
      e_bz = 1;
      if (age < LAT) begin
        e_sf = 1; e_sd = 1; e_se = 1; e_bm = 1;
      end else begin
        e_va = 1;
      end
    end else if (mdu) begin
      e_st = 1; e_sf = 1; e_sd = 1; e_se = 1; e_bm = 1;
    end else if (redir) begin
      e_fd = 1; e_fe = 1;
    end else if (luse_m) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
    e = {e_sf, e_sd, e_se, e_fd, e_fe, e_bm, e_st, e_va, e_bz};
    a = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, mdu_start, mdu_valid, busy};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL ctrl t=%0t got %b want %b (sF sD sE fD fE bM st va bz)", $time, a, e);
    end
    vectors++;
    if (int'(stall_cycles) != (rst_n ? perf : 0)) begin
      miscompares++;
      $display("FAIL stall_cycles t=%0t got %0d want %0d", $time, stall_cycles, rst_n ? perf : 0);
    end
    if (!rst_n) begin
      age = -1;
      perf = 0;
    end else begin
      if (e_sf) perf = (perf < SAT) ? perf + 1 : SAT;
      if (age >= 0) age = (age == LAT) ? -1 : age + 1;
      else if (mdu) age = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic us1, input logic us2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic br, input logic md);
    @(posedge clk);
    #1;
    rst_n = r; rs1 = a1; rs2 = a2; u1 = us1; u2 = us2; rde = rd;
    wren = we; rden = ld; redir = br; mdu = md;
    #2;
  endtask

  initial begin
    // reset state
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_flushD", flush_d, 1);
    chk("rst_flushE", flush_e, 1);
    chk("rst_stallF", stall_f, 0);
    chk("rst_cnt", stall_cycles, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_flushD", flush_d, 0);
    chk("idle_busy", busy, 0);

    // load then dependent use
    apply(1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    chk("luse_stallF", stall_f, 1);
    chk("luse_stallD", stall_d, 1);
    chk("luse_flushE", flush_e, 1);
    chk("luse_stallE", stall_e, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("luse_release", stall_f, 0);
    chk("luse_cnt", stall_cycles, 1);

    // x0 destination, then rs2-only match
    apply(1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    chk("x0_no_stall", stall_f, 0);
    apply(1, 5, 5, 0, 1, 5, 1, 1, 0, 0);
    chk("rs2_stall", stall_f, 1);

    // redirect with a matching register pair but no load
    apply(1, 5, 0, 1, 0, 5, 1, 0, 1, 0);
    chk("redir_flushD", flush_d, 1);
    chk("redir_flushE", flush_e, 1);
    chk("redir_stallF", stall_f, 0);
    chk("redir_stallD", stall_d, 0);
    chk("redir_cnt", stall_cycles, 2);

    // MDU op with request held through release
    for (int i = 0; i <= LAT; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("mdu_start", mdu_start, (i == 0) ? 1 : 0);
      chk("mdu_stallE", stall_e, (i < LAT) ? 1 : 0);
      chk("mdu_bubbleM", bubble_m, (i < LAT) ? 1 : 0);
      chk("mdu_valid", mdu_valid, (i == LAT) ? 1 : 0);
    end
    chk("mdu_cnt", stall_cycles, 6);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mdu_done_busy", busy, 0);
    chk("mdu_done_start", mdu_start, 0);

    // reset in the middle of an MDU op
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mrst_flushD", flush_d, 1);
    chk("mrst_flushE", flush_e, 1);
    chk("mrst_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mrst_no_valid", mdu_valid, 0);
      chk("mrst_busy_after", busy, 0);
    end
    chk("mrst_cnt", stall_cycles, 0);

    // back-to-back MDU ops saturate the counter
    for (int i = 0; i < 30; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_cnt", stall_cycles, SAT);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic, one EX instruction class at a time
    for (int i = 0; i < 2000; i++) begin
      int k;
      logic r;
      k = $urandom_range(0, 3);
      r = ($urandom_range(0, 60) != 0);
      apply(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            k == 1, k == 2, k == 3);
    end

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
